// File: rtl/alu_arb_pkg.sv
// Shared definitions for the ALU arbiter: op encodings, FSM states and the ALU datapath width.
package alu_arb_pkg;

    localparam int ALU_WIDTH = 20;

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_XOR = 2'b10;
    localparam logic [1:0] OP_ADD = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } arb_state_t;

endpackage

// File: rtl/alu_rr_picker.sv
// Combinational round-robin picker: first valid requester at or above rr_ptr, wrapping modulo NREQ.
// Generic enough to front any other shared resource.
module alu_rr_picker #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_valid,
    input  logic [IDW-1:0]  rr_ptr,
    output logic            any,
    output logic [IDW-1:0]  winner
);

    always_comb begin
        int w_idx;
        any    = |req_valid;
        winner = '0;
        w_idx  = 0;
        // Walk from the farthest offset back to rr_ptr so the nearest valid one wins.
        for (int k = NREQ - 1; k >= 0; k--) begin
            w_idx = (int'(rr_ptr) + k) % NREQ;
            if (req_valid[w_idx]) begin
                winner = w_idx[IDW-1:0];
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter/sequencer sharing one external ALU among NREQ requesters; accept -> rsp_valid is 2 cycles.
// Holds in RESP while rsp_ready is low. Optional grant counters under ALU_ARB_STATS_EN.
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter  int NREQ  = 4,
    parameter  int WIDTH = ALU_WIDTH,
    localparam int IDW   = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_in0,
    input  logic [NREQ*WIDTH-1:0] req_in1,
    input  logic [NREQ*2-1:0]     req_op,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [WIDTH-1:0]      rsp_data,
    output logic [WIDTH-1:0]      alu_in0,
    output logic [WIDTH-1:0]      alu_in1,
    output logic [1:0]            alu_sel,
    input  logic [WIDTH-1:0]      alu_out,
    output logic                  busy
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [NREQ*16-1:0]    grant_cnt
`endif
);

    arb_state_t       r_state, w_next;
    logic [WIDTH-1:0] r_in0, r_in1, r_rsp_data;
    logic [1:0]       r_op;
    logic [IDW-1:0]   r_id, r_rr_ptr, r_rsp_id;
    logic             w_any, w_accept, w_rsp_hs;
    logic [IDW-1:0]   w_winner;

    alu_rr_picker #(.NREQ(NREQ), .IDW(IDW)) u_picker (
        .req_valid (req_valid),
        .rr_ptr    (r_rr_ptr),
        .any       (w_any),
        .winner    (w_winner)
    );

    assign w_accept = (r_state == IDLE) && w_any;
    assign w_rsp_hs = (r_state == RESP) && rsp_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_any) w_next = ISSUE;
            ISSUE:   w_next = RESP;
            RESP:    if (rsp_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        if (w_accept) req_ready[w_winner] = 1'b1;
        rsp_valid = (r_state == RESP);
        busy      = (r_state != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in0      <= '0;
            r_in1      <= '0;
            r_op       <= OP_AND;
            r_id       <= '0;
            r_rr_ptr   <= '0;
            r_rsp_data <= '0;
            r_rsp_id   <= '0;
        end else begin
            if (w_accept) begin
                r_in0 <= req_in0[w_winner*WIDTH +: WIDTH];
                r_in1 <= req_in1[w_winner*2*0 + w_winner*WIDTH +: WIDTH];
                r_op  <= req_op[w_winner*2 +: 2];
                r_id  <= w_winner;
            end
            if (r_state == ISSUE) begin
                r_rsp_data <= alu_out;
                r_rsp_id   <= r_id;
            end
            // Next search starts just past the requester that was served.
            if (w_rsp_hs) begin
                r_rr_ptr <= (r_id == IDW'(NREQ - 1)) ? '0 : r_id + 1'b1;
            end
        end
    end

    assign alu_in0  = r_in0;
    assign alu_in1  = r_in1;
    assign alu_sel  = r_op;
    assign rsp_data = r_rsp_data;
    assign rsp_id   = r_rsp_id;

`ifdef ALU_ARB_STATS_EN
    logic [15:0] r_grant_cnt [NREQ];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREQ; i++) r_grant_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (w_accept && (w_winner == IDW'(i)) && (r_grant_cnt[i] != 16'hFFFF)) begin
                    r_grant_cnt[i] <= r_grant_cnt[i] + 16'd1;
                end
            end
        end
    end

    always_comb begin
        grant_cnt = '0;
        for (int i = 0; i < NREQ; i++) grant_cnt[i*16 +: 16] = r_grant_cnt[i];
    end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomised scoreboard bench for alu_arbiter; grant order and results come from a round-robin reference model.
`timescale 1ns/1ps
module tb_alu_arbiter;
    localparam int NREQ = 4;
    localparam int W    = 20;
    localparam int IDW  = 2;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [NREQ-1:0]     req_valid = '0;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ*W-1:0]   req_in0 = '0;
    logic [NREQ*W-1:0]   req_in1 = '0;
    logic [NREQ*2-1:0]   req_op = '0;
    logic                rsp_valid;
    logic                rsp_ready = 1'b0;
    logic [IDW-1:0]      rsp_id;
    logic [W-1:0]        rsp_data, alu_in0, alu_in1, alu_out;
    logic [1:0]          alu_sel;
    logic                busy;
`ifdef ALU_ARB_STATS_EN
    logic [NREQ*16-1:0]  grant_cnt;
`endif

    alu_arbiter #(.NREQ(NREQ), .WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_in0(req_in0), .req_in1(req_in1), .req_op(req_op),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .alu_in0(alu_in0), .alu_in1(alu_in1), .alu_sel(alu_sel), .alu_out(alu_out), .busy(busy)
`ifdef ALU_ARB_STATS_EN
        , .grant_cnt(grant_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] ref_alu(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op);
        longint unsigned s;
        case (op)
            2'b00:   return a & b;
            2'b01:   return a | b;
            2'b10:   return a ^ b;
            default: begin
                s = longint'(a) + longint'(b);
                return W'(s % (64'd1 << W));
            end
        endcase
    endfunction

    // The shared ALU lives in the parent; the bench plays that role.
    assign alu_out = ref_alu(alu_in0, alu_in1, alu_sel);

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        int         id;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [1:0]   op;
        logic [W-1:0] res;
    } exp_t;

    exp_t exp_q[$];
    int   grant_q[$];
    int   lat_q[$];
    int   model_ptr = 0;
    int   model_cnt [NREQ];
    logic [W-1:0] s_in0 [NREQ];
    logic [W-1:0] s_in1 [NREQ];
    logic [1:0]   s_op  [NREQ];
    int   rr_mode = 0;  // 0 random, 1 hold low, 2 hold high

    always @(posedge clk) begin
        #2;
        case (rr_mode)
            1:       rsp_ready = 1'b0;
            2:       rsp_ready = 1'b1;
            default: rsp_ready = ($urandom_range(3) != 0);
        endcase
    end

    // Round-robin model: every requester in the batch is served once, in circular order from the pointer.
    task automatic run_batch(input logic [NREQ-1:0] mask);
        int last;
        int cyc;
        logic [NREQ-1:0] pending, done;
        exp_t e;
        last = -1;
        for (int k = 0; k < NREQ; k++) begin
            int id;
            id = (model_ptr + k) % NREQ;
            if (mask[id]) begin
                grant_q.push_back(id);
                e.id = id; e.a = s_in0[id]; e.b = s_in1[id]; e.op = s_op[id];
                e.res = ref_alu(s_in0[id], s_in1[id], s_op[id]);
                exp_q.push_back(e);
                model_cnt[id]++;
                last = id;
            end
        end
        if (last >= 0) model_ptr = (last + 1) % NREQ;
        for (int i = 0; i < NREQ; i++) begin
            if (mask[i]) begin
                req_in0[i*W +: W] = s_in0[i];
                req_in1[i*W +: W] = s_in1[i];
                req_op[i*2 +: 2]  = s_op[i];
            end
        end
        req_valid = mask;
        pending = mask;
        cyc = 0;
        while (pending != 0 && cyc < 300) begin
            @(negedge clk);
            done = req_ready & req_valid;
            @(posedge clk);
            #1;
            req_valid = req_valid & ~done;
            pending = pending & ~done;
            cyc++;
        end
        if (pending != 0) check("batch_accept_timeout", pending, 0);
        req_valid = '0;
    endtask

    task automatic drain();
        int cyc;
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 500) begin
            @(posedge clk);
            cyc++;
        end
        check("drain_remaining", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    function automatic int idx_of(input logic [NREQ-1:0] v);
        for (int i = 0; i < NREQ; i++) if (v[i]) return i;
        return -1;
    endfunction

    // Monitor: samples on the falling edge, away from the DUT's active edge.
    int           cyc_n = 0;
    logic         prev_v = 1'b0;
    logic [W-1:0] prev_data;
    logic [IDW-1:0] prev_id;
    exp_t         me;

    always @(negedge clk) begin
        cyc_n++;
        if (!rst_n) begin
            prev_v = 1'b0;
        end else begin
            check("ready_at_most_one", ($countones(req_ready) <= 1), 1);
            if (busy) check("ready_while_busy", req_ready, 0);
            if (req_ready != 0) begin
                lat_q.push_back(cyc_n);
                check("grant_expected", (grant_q.size() > 0), 1);
                if (grant_q.size() > 0) check("grant_id", idx_of(req_ready), grant_q.pop_front());
            end
            if (busy) begin
                check("busy_has_expected", (exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    me = exp_q[0];
                    check("alu_in0_held", alu_in0, me.a);
                    check("alu_in1_held", alu_in1, me.b);
                    check("alu_sel_held", alu_sel, me.op);
                end
            end
            if (rsp_valid) begin
                if (!prev_v) begin
                    check("latency_has_accept", (lat_q.size() > 0), 1);
                    if (lat_q.size() > 0) check("accept_to_rsp_cycles", cyc_n - lat_q.pop_front(), 2);
                end else begin
                    check("rsp_data_stable", rsp_data, prev_data);
                    check("rsp_id_stable", rsp_id, prev_id);
                end
                if (rsp_ready && exp_q.size() > 0) begin
                    me = exp_q.pop_front();
                    check("rsp_id", rsp_id, me.id);
                    check("rsp_data", rsp_data, me.res);
                end
            end
            prev_v    = rsp_valid && !rsp_ready;
            prev_data = rsp_data;
            prev_id   = rsp_id;
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, req_ready, 0);
        check({tag, "_rsp_valid"}, rsp_valid, 0);
        check({tag, "_rsp_data"},  rsp_data, 0);
        check({tag, "_rsp_id"},    rsp_id, 0);
        check({tag, "_alu_in0"},   alu_in0, 0);
        check({tag, "_alu_in1"},   alu_in1, 0);
        check({tag, "_alu_sel"},   alu_sel, 0);
        check({tag, "_busy"},      busy, 0);
`ifdef ALU_ARB_STATS_EN
        check({tag, "_grant_cnt"}, grant_cnt, 0);
`endif
    endtask

    initial begin
        int wait_cyc;
        for (int i = 0; i < NREQ; i++) model_cnt[i] = 0;

        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single ADD from requester 0.
        s_in0[0] = 20'h0000F; s_in1[0] = 20'h00003; s_op[0] = 2'b11;
        run_batch(4'b0001);
        drain();

        // Wrap-around ADD plus the three logic ops, all pending at once.
        s_in0[1] = 20'hFFFFF; s_in1[1] = 20'h00001; s_op[1] = 2'b11;
        s_in0[2] = 20'hF0F0F; s_in1[2] = 20'h0FF00; s_op[2] = 2'b00;
        s_in0[3] = 20'hF0F0F; s_in1[3] = 20'h0FF00; s_op[3] = 2'b01;
        s_in0[0] = 20'hF0F0F; s_in1[0] = 20'h0FF00; s_op[0] = 2'b10;
        run_batch(4'b1111);
        drain();

        // Backpressure: response held for 5 cycles.
        rr_mode = 1;
        s_in0[1] = 20'h12345; s_in1[1] = 20'h0ABCD; s_op[1] = 2'b10;
        run_batch(4'b0010);
        wait_cyc = 0;
        while (!rsp_valid && wait_cyc < 20) begin
            @(negedge clk);
            wait_cyc++;
        end
        check("bp_rsp_seen", rsp_valid, 1);
        repeat (5) @(negedge clk);
        check("bp_still_valid", rsp_valid, 1);
        check("bp_no_ready", req_ready, 0);
        @(posedge clk);
        #1;
        rr_mode = 2;
        @(negedge clk);
        check("bp_release_hs", rsp_valid && rsp_ready, 1);
        @(negedge clk);
        check("bp_done_busy", busy, 0);
        rr_mode = 0;
        drain();

        // Reset while in ISSUE: in-flight operation must vanish.
        s_in0[2] = 20'h00777; s_in1[2] = 20'h00111; s_op[2] = 2'b11;
        run_batch(4'b0100);
        check("pre_reset_in_issue", busy && !rsp_valid, 1);
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        grant_q.delete();
        lat_q.delete();
        model_ptr = 0;
        for (int i = 0; i < NREQ; i++) model_cnt[i] = 0;
        check_reset_outputs("midop_reset");
        repeat (3) @(negedge clk);
        check("no_rsp_after_reset", rsp_valid, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Fairness from a fresh pointer: 0,1,2,3 then 0.
        for (int i = 0; i < NREQ; i++) begin
            s_in0[i] = W'($urandom); s_in1[i] = W'($urandom); s_op[i] = 2'($urandom);
        end
        run_batch(4'b1111);
        s_in0[0] = W'($urandom); s_in1[0] = W'($urandom); s_op[0] = 2'($urandom);
        run_batch(4'b0001);
        drain();

        // Random batches.
        for (int n = 0; n < 40; n++) begin
            logic [NREQ-1:0] m;
            m = NREQ'($urandom_range(15, 1));
            for (int i = 0; i < NREQ; i++) begin
                s_in0[i] = W'($urandom); s_in1[i] = W'($urandom); s_op[i] = 2'($urandom);
                if ($urandom_range(3) == 0) s_in0[i] = 20'hFFFFF;
            end
            run_batch(m);
            if ($urandom_range(2) == 0) drain();
        end
        drain();

`ifdef ALU_ARB_STATS_EN
        for (int i = 0; i < NREQ; i++) check("grant_cnt", grant_cnt[i*16 +: 16], model_cnt[i]);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1);
    end

endmodule
